// File: rtl/parking_input_conditioner_if.sv
// Switch-side signal bundle for the parking input conditioner: raw switches in,
// conditioned one-cycle events out.
interface parking_input_conditioner_if;
    logic       car_enter_raw;
    logic       car_exit_raw;
    logic [2:0] car_sel_raw;
    logic       car_enter;
    logic       car_exit;
    logic [2:0] car_sel;
    logic       sel_error;
    logic       busy;

    modport master (
        output car_enter_raw, car_exit_raw, car_sel_raw,
        input  car_enter, car_exit, car_sel, sel_error, busy
    );

    modport slave (
        input  car_enter_raw, car_exit_raw, car_sel_raw,
        output car_enter, car_exit, car_sel, sel_error, busy
    );
endinterface

// File: rtl/parking_input_conditioner.sv
// Synchronizes and debounces the parking switches, then turns each press into one event pulse.
// Optional macro SEL_ONEHOT_CHECK_EN rejects non-one-hot slot selects with a sel_error pulse.
module parking_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 20
) (
    input logic                        clk,
    input logic                        reset,
    parking_input_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCapture, StIssue, StWaitRel} state_e;

    logic [4:0]       raw;
    logic [4:0]       sync1_q, sync2_q, deb_q;
    logic [CNT_W-1:0] cnt_q [5];

    state_e     state_q;
    logic       is_enter_q;
    logic       car_enter_q, car_exit_q, sel_error_q, busy_q;
    logic [2:0] car_sel_q;

    logic       deb_enter, deb_exit;
    logic [2:0] deb_sel;

    // Bit order: [0] enter, [1] exit, [4:2] slot select.
    assign raw       = {bus.car_sel_raw, bus.car_exit_raw, bus.car_enter_raw};
    assign deb_enter = deb_q[0];
    assign deb_exit  = deb_q[1];
    assign deb_sel   = deb_q[4:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntMax) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Outputs are registered: the pulse set on the CAPTURE edge is visible for the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            is_enter_q  <= 1'b0;
            car_enter_q <= 1'b0;
            car_exit_q  <= 1'b0;
            car_sel_q   <= 3'b000;
            sel_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            car_enter_q <= 1'b0;
            car_exit_q  <= 1'b0;
            sel_error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (deb_enter ^ deb_exit) begin
                        state_q    <= StCapture;
                        is_enter_q <= deb_enter;
                        busy_q     <= 1'b1;
                    end else if (deb_enter && deb_exit) begin
                        state_q <= StWaitRel;
                        busy_q  <= 1'b1;
                    end
                end
                StCapture: begin
                    car_sel_q <= deb_sel;
                    state_q   <= StIssue;
`ifdef SEL_ONEHOT_CHECK_EN
                    // deb_sel is exactly the value being captured into car_sel on this edge.
                    if (!$onehot(deb_sel)) begin
                        sel_error_q <= 1'b1;
                    end else begin
                        car_enter_q <= is_enter_q;
                        car_exit_q  <= ~is_enter_q;
                    end
`else
                    car_enter_q <= is_enter_q;
                    car_exit_q  <= ~is_enter_q;
`endif
                end
                StIssue: begin
                    state_q <= StWaitRel;
                end
                StWaitRel: begin
                    if (!deb_enter && !deb_exit) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.car_enter = car_enter_q;
    assign bus.car_exit  = car_exit_q;
    assign bus.car_sel   = car_sel_q;
    assign bus.sel_error = sel_error_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_parking_input_conditioner.sv
// Directed bench for parking_input_conditioner (DEBOUNCE_CYCLES=16) with an event scoreboard;
// expectations follow SEL_ONEHOT_CHECK_EN when the macro is defined for the build.
module tb_parking_input_conditioner;

    localparam int unsigned Deb     = 16;
    localparam int unsigned Latency = Deb + 4;

    typedef struct packed {
        logic [31:0] at;
        logic        enter;
        logic        exit;
        logic        err;
        logic [2:0]  sel;
    } event_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    event_t sb[$];

    parking_input_conditioner_if pif ();

    parking_input_conditioner #(
        .DEBOUNCE_CYCLES(Deb),
        .CNT_W          (20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (pif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score any event pulse seen there.
    task automatic tick();
        event_t e;
        logic [2:0] pulse;
        @(negedge clk);
        pulse = {pif.car_enter, pif.car_exit, pif.sel_error};
        if (sb.size() != 0 && cyc > int'(sb[0].at)) begin
            e = sb.pop_front();
            check("missed_event", 32'(cyc), e.at);
        end
        if (pulse != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {26'd0, pif.car_sel, pulse}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("event_edge", 32'(cyc), e.at);
                check("event_kind", {29'd0, pulse}, {29'd0, e.enter, e.exit, e.err});
                check("event_sel", {29'd0, pif.car_sel}, {29'd0, e.sel});
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_event(input logic enter, input logic exit, input logic err,
                                input logic [2:0] sel);
        event_t e;
        e.at    = 32'(cyc + Latency);
        e.enter = enter;
        e.exit  = exit;
        e.err   = err;
        e.sel   = sel;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] all_outs();
        return {25'd0, pif.car_enter, pif.car_exit, pif.car_sel, pif.sel_error, pif.busy};
    endfunction

    initial begin
        int   d;
        int   r;
        logic busy_seen;

        reset             = 1'b1;
        pif.car_enter_raw = 1'b0;
        pif.car_exit_raw  = 1'b0;
        pif.car_sel_raw   = 3'b000;
        run(3);
        check("reset_outputs", all_outs(), 32'd0);
        reset = 1'b0;
        run(5);

        // Plain enter press with slot 010.
        pif.car_sel_raw   = 3'b010;
        pif.car_enter_raw = 1'b1;
        expect_event(1'b1, 1'b0, 1'b0, 3'b010);
        run(Latency - 1);
        check("sel_before_capture", {29'd0, pif.car_sel}, 32'd0);
        check("busy_during_press", {31'd0, pif.busy}, 32'd1);
        run(40 - (Latency - 1));
        pif.car_enter_raw = 1'b0;
        run(30);
        check("busy_after_release", {31'd0, pif.busy}, 32'd0);
        check("sel_held", {29'd0, pif.car_sel}, 32'h2);

        // Short exit glitch must be swallowed.
        busy_seen        = 1'b0;
        pif.car_exit_raw = 1'b1;
        repeat (10) begin
            tick();
            busy_seen |= pif.busy;
        end
        pif.car_exit_raw = 1'b0;
        repeat (30) begin
            tick();
            busy_seen |= pif.busy;
        end
        check("glitch_busy", {31'd0, busy_seen}, 32'd0);

        // Both switches together: no event, busy until both released.
        pif.car_enter_raw = 1'b1;
        pif.car_exit_raw  = 1'b1;
        run(25);
        check("both_busy", {31'd0, pif.busy}, 32'd1);
        pif.car_sel_raw = 3'b111;
        run(15);
        pif.car_enter_raw = 1'b0;
        pif.car_exit_raw  = 1'b0;
        run(10);
        check("both_busy_release", {31'd0, pif.busy}, 32'd1);
        check("both_sel_unchanged", {29'd0, pif.car_sel}, 32'h2);
        run(20);
        check("both_idle", {31'd0, pif.busy}, 32'd0);

        // Non-one-hot select on an enter press.
        pif.car_sel_raw   = 3'b011;
        pif.car_enter_raw = 1'b1;
`ifdef SEL_ONEHOT_CHECK_EN
        expect_event(1'b0, 1'b0, 1'b1, 3'b011);
`else
        expect_event(1'b1, 1'b0, 1'b0, 3'b011);
`endif
        run(40);
        pif.car_enter_raw = 1'b0;
        run(30);

        // Exit press with slot 100.
        pif.car_sel_raw  = 3'b100;
        pif.car_exit_raw = 1'b1;
        expect_event(1'b0, 1'b1, 1'b0, 3'b100);
        run(40);
        pif.car_exit_raw = 1'b0;
        run(30);
        check("exit_busy_done", {31'd0, pif.busy}, 32'd0);

        // Reset on edge 18 of a press, switch held through reset release.
        pif.car_sel_raw   = 3'b001;
        pif.car_enter_raw = 1'b1;
        d = cyc;
        run(17);
        reset = 1'b1;
        run(3);
        check("midreset_outputs", all_outs(), 32'd0);
        check("midreset_cycle", 32'(cyc), 32'(d + 20));
        reset = 1'b0;
        r = cyc;
        expect_event(1'b1, 1'b0, 1'b0, 3'b001);
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        check("post_reset_event_cycle", 32'(r + Latency), 32'(cyc));
        run(20);
        pif.car_enter_raw = 1'b0;
        run(30);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
